mult_div_controller: RTL
========================

Name: mult_div_controller

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU, placed beside the EX-stage ALU.
- Consumes the ALU's post-forwarding operands (rs, rt) and owns the architectural HI/LO registers.
- Runs an iterative shift-add multiplier or restoring divider for DATA_WIDTH iterations.
- Asserts a stall to the hazard unit whenever the pipeline touches HI/LO or issues a new op while busy.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH; counter width is clog2(DATA_WIDTH).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
startInput  input  1  issue a mult/div (qualified EX-stage decode)
opInput  input  2  operation code, mult_div_pkg::md_op_t
dataRsInput  input  DATA_WIDTH  forwarded rs (multiplicand/dividend)
dataRtInput  input  DATA_WIDTH  forwarded rt (multiplier/divisor)
hiLoReadInput  input  1  MFHI/MFLO in EX
hiWriteInput  input  1  MTHI
loWriteInput  input  1  MTLO
hiLoWriteDataInput  input  DATA_WIDTH  MTHI/MTLO data
hiOutput  output  DATA_WIDTH  HI register
loOutput  output  DATA_WIDTH  LO register
busyOutput  output  1  operation in flight
doneOutput  output  1  one-cycle pulse when HI/LO updated by an op
stallOutput  output  1  combinational stall request to the hazard unit

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; hi/lo=0; busy=0; done=0; counter=0.
  - An in-flight op is discarded; HI/LO are not partially updated.
- States: IDLE, RUN, FIX.
- IDLE:
  - On startInput at edge E0, latch operands as magnitudes (signed ops take the absolute value; |0x80000000| = 2^31 unsigned).
  - Also latch the sign flags and the op; counter=0; go to RUN.
  - busy rises after E0.
- RUN: one iteration per edge, at E1..E32.
  - Multiply: add-shift into the 2*DATA_WIDTH product.
  - Divide: restoring shift-subtract, one quotient bit per edge.
  - After the iteration where counter==DATA_WIDTH-1, go to FIX.
- FIX (edge E33): apply sign correction, write HI/LO, done=1 for the following cycle only; busy=0 after E33; go to IDLE.
- Latency: results are visible on hiOutput/loOutput in the cycle after E33, i.e. 34 edges after the start edge. A new start is accepted on the done cycle.
- Multiply result: hi:lo = full 2*DATA_WIDTH product; negated when exactly one operand of MULT is negative.
- Divide result: lo=quotient, hi=remainder.
  - Signed: quotient negated if the operand signs differ; remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU): hi=dataRs, lo=all-ones, same latency, no exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stallOutput = busyOutput & (startInput | hiLoReadInput | hiWriteInput | loWriteInput).
  - While busy, these requests are ignored (the pipeline holds them).
  - Busy is low on the done cycle, so a stalled MFHI/MFLO reads the new value then.
- MTHI/MTLO in IDLE: update hi or lo at the edge. If startInput is also high, start wins and the write is ignored; the decoder never issues both.
- opInput, dataRs and dataRt are sampled only at the start edge; later changes have no effect.

Decomposition:
- Package mult_div_pkg:
  - md_op_t: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - md_state_t: IDLE, RUN, FIX.
  - Constant MD_ITERATIONS=DATA_WIDTH.
- Sub-module mult_div_step: combinational single iteration.
  - Multiply: conditional add plus shift.
  - Divide: trial subtract plus quotient bit.
  - Controller keeps state, counter, sign flags and HI/LO.

Test Plan:
1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly once, 34 edges after start; busy high for 33 cycles.
2. MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
3. Sign rules for divide:
   - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU 7/2 -> lo=3, hi=1.
4. Divide corner cases:
   - DIV 0x12345678/0 -> hi=0x12345678, lo=0xFFFFFFFF.
   - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Requests while busy:
   - Start a MULTU; at cycle 10 pulse startInput and hold hiLoReadInput -> stallOutput=1 each busy cycle, second start ignored, first result intact.
   - Stall drops on the done cycle.
   - MTHI during busy leaves HI unchanged.
6. Reset mid-operation:
   - reset=0 at cycle 15 of a DIV -> next cycle busy=0, hi=lo=0, no done pulse.
   - A subsequent MULTU 5*6 completes with lo=30, hi=0.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide sequencer.
package mult_div_pkg;

  localparam int MD_DATA_WIDTH = 32;
  localparam int MD_ITERATIONS = MD_DATA_WIDTH;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic is_div_op(md_op_t op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(md_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Pipeline-side bundle for the mult/div unit: issue, HI/LO access and status.
interface mult_div_if
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
);
  // startInput is a qualified issue: it is taken only while the unit is idle;
  // while busy every request is held by the pipeline under stallOutput.
  logic                  startInput;
  md_op_t                opInput;
  logic [DATA_WIDTH-1:0] dataRsInput;
  logic [DATA_WIDTH-1:0] dataRtInput;
  logic                  hiLoReadInput;
  logic                  hiWriteInput;
  logic                  loWriteInput;
  logic [DATA_WIDTH-1:0] hiLoWriteDataInput;
  logic [DATA_WIDTH-1:0] hiOutput;
  logic [DATA_WIDTH-1:0] loOutput;
  logic                  busyOutput;
  logic                  doneOutput;
  logic                  stallOutput;

  modport master (
    output startInput, opInput, dataRsInput, dataRtInput,
    output hiLoReadInput, hiWriteInput, loWriteInput, hiLoWriteDataInput,
    input  hiOutput, loOutput, busyOutput, doneOutput, stallOutput
  );

  modport slave (
    input  startInput, opInput, dataRsInput, dataRtInput,
    input  hiLoReadInput, hiWriteInput, loWriteInput, hiLoWriteDataInput,
    output hiOutput, loOutput, busyOutput, doneOutput, stallOutput
  );

endinterface

// File: rtl/mult_div_step.sv
// One combinational iteration of shift-add multiply or restoring divide
// over the packed {upper, lower} accumulator.
module mult_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  logic                    is_div,
  output logic [2*DATA_WIDTH-1:0] acc_next
);

  localparam int W = DATA_WIDTH;

  logic [W:0] mul_sum;
  logic [W:0] div_diff;

  // Multiply: the multiplier sits in the low half and is consumed from bit 0.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
  // Divide: remainder shifted left with the next dividend bit, then trial subtract.
  assign div_diff = acc[2*W-1:W-1] - {1'b0, operand};

  always_comb begin
    acc_next = acc;
    if (is_div) begin
      if (!div_diff[W]) acc_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      else              acc_next = {acc[2*W-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_controller.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO and stalls the
// pipeline while an operation is in flight.
module mult_div_controller
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus,
  output md_state_t  dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  md_state_t         state_q, state_d;
  logic [CW-1:0]     count_q;
  logic [2*W-1:0]    acc_q, acc_step;
  logic [W-1:0]      opnd_q, hi_q, lo_q;
  md_op_t            op_q;
  logic              rs_neg_q, rt_neg_q, div_zero_q, done_q;

  logic              start_ok, last_iter, signed_start;
  logic [W-1:0]      rs_mag, rt_mag;
  logic [2*W-1:0]    mul_res;
  logic [W-1:0]      quot_res, rem_res;

  assign start_ok     = bus.startInput && (state_q == IDLE);
  assign last_iter    = (count_q == CW'(W - 1));
  assign signed_start = is_signed_op(bus.opInput);
  assign rs_mag       = (signed_start && bus.dataRsInput[W-1]) ? -bus.dataRsInput : bus.dataRsInput;
  assign rt_mag       = (signed_start && bus.dataRtInput[W-1]) ? -bus.dataRtInput : bus.dataRtInput;

  mult_div_step #(.DATA_WIDTH(W)) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .is_div   (is_div_op(op_q)),
    .acc_next (acc_step)
  );

  // With a zero divisor the restoring loop leaves |rs| as remainder, so the
  // sign fix already restores rs into HI; only LO needs forcing to all-ones.
  assign mul_res  = (rs_neg_q ^ rt_neg_q) ? -acc_q : acc_q;
  assign quot_res = div_zero_q ? {W{1'b1}}
                  : ((rs_neg_q ^ rt_neg_q) ? -acc_q[W-1:0] : acc_q[W-1:0]);
  assign rem_res  = rs_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      op_q       <= MD_MULT;
      rs_neg_q   <= 1'b0;
      rt_neg_q   <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            op_q       <= bus.opInput;
            rs_neg_q   <= signed_start & bus.dataRsInput[W-1];
            rt_neg_q   <= signed_start & bus.dataRtInput[W-1];
            div_zero_q <= (bus.dataRtInput == '0);
            count_q    <= '0;
            acc_q      <= is_div_op(bus.opInput) ? {{W{1'b0}}, rs_mag} : {{W{1'b0}}, rt_mag};
            opnd_q     <= is_div_op(bus.opInput) ? rt_mag : rs_mag;
          end else begin
            if (bus.hiWriteInput) hi_q <= bus.hiLoWriteDataInput;
            if (bus.loWriteInput) lo_q <= bus.hiLoWriteDataInput;
          end
        end
        RUN: begin
          acc_q   <= acc_step;
          count_q <= count_q + 1'b1;
        end
        FIX: begin
          if (is_div_op(op_q)) begin
            hi_q <= rem_res;
            lo_q <= quot_res;
          end else begin
            hi_q <= mul_res[2*W-1:W];
            lo_q <= mul_res[W-1:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hiOutput    = hi_q;
  assign bus.loOutput    = lo_q;
  assign bus.busyOutput  = (state_q != IDLE);
  assign bus.doneOutput  = done_q;
  assign bus.stallOutput = bus.busyOutput &
                           (bus.startInput | bus.hiLoReadInput | bus.hiWriteInput | bus.loWriteInput);
  assign dbg_state       = state_q;

endmodule
